// File: rtl/pingpong_frame_sched.sv
// pingpong_frame_sched: ping-pong SPRAM frame buffer control between UART RX and UART TX.
// One bank collects received bytes while the other is read back out byte by byte.
module pingpong_frame_sched #(
    parameter int ADDR_W    = 14,
    parameter int CNT_W     = 9,
    parameter int FRAME_EOP = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_ready_i,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_eop_i,
    output logic [ADDR_W-1:0] ram_addr_a_o,
    output logic              ram_wren_a_o,
    output logic [ADDR_W-1:0] ram_addr_b_o,
    output logic              ram_wren_b_o,
    output logic [15:0]       ram_din_o,
    input  logic [15:0]       ram_dout_a_i,
    input  logic [15:0]       ram_dout_b_i,
    output logic              tx_start_o,
    output logic [7:0]        tx_data_o,
    input  logic              tx_busy_i,
    output logic              wr_bank_o,
    output logic              rd_active_o,
    output logic              frame_drop_o,
    output logic              wr_ovf_o
);
    localparam int EOP_W = $clog2(FRAME_EOP + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {IDLE, RD, CAP, START, DONE} state_t;

    state_t           state_q, state_d;
    logic             wr_bank_q, wr_bank_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [EOP_W-1:0] eop_cnt_q, eop_cnt_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0] rd_len_q, rd_len_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             drop_q, drop_d;
    logic             ovf_q, ovf_d;

    logic             wr_en;
    logic [CNT_W-1:0] wr_len;
    logic             close;
    logic [15:0]      rd_dout;
    logic             unused_dout_hi;

    // A saturated write counter stops further writes so the frame never wraps onto itself.
    assign wr_en   = rx_ready_i && (wr_cnt_q != CNT_MAX);
    assign wr_len  = wr_cnt_q + CNT_W'(wr_en);
    assign close   = rx_eop_i && (eop_cnt_q == EOP_W'(FRAME_EOP - 1));
    assign rd_dout = wr_bank_q ? ram_dout_a_i : ram_dout_b_i;
    assign unused_dout_hi = ^rd_dout[15:8];

    assign ram_addr_a_o = wr_bank_q ? ADDR_W'(rd_cnt_q) : ADDR_W'(wr_cnt_q);
    assign ram_addr_b_o = wr_bank_q ? ADDR_W'(wr_cnt_q) : ADDR_W'(rd_cnt_q);
    assign ram_wren_a_o = !wr_bank_q && wr_en;
    assign ram_wren_b_o = wr_bank_q && wr_en;
    assign ram_din_o    = {8'h00, rx_data_i};
    assign tx_start_o   = (state_q == START);
    assign tx_data_o    = tx_data_q;
    assign wr_bank_o    = wr_bank_q;
    assign rd_active_o  = (state_q != IDLE);
    assign frame_drop_o = drop_q;
    assign wr_ovf_o     = ovf_q;

    always_comb begin
        state_d   = state_q;
        wr_bank_d = wr_bank_q;
        rd_cnt_d  = rd_cnt_q;
        rd_len_d  = rd_len_q;
        tx_data_d = tx_data_q;
        drop_d    = 1'b0;
        wr_cnt_d  = wr_len;
        eop_cnt_d = rx_eop_i ? eop_cnt_q + EOP_W'(1) : eop_cnt_q;
        ovf_d     = ovf_q | (rx_ready_i & ~wr_en);
        case (state_q)
            RD:      state_d = CAP;
            CAP: begin
                tx_data_d = rd_dout[7:0];
                state_d   = START;
            end
            START:   state_d = tx_busy_i ? DONE : START;
            DONE: begin
                if (!tx_busy_i) begin
                    state_d  = (rd_cnt_q == rd_len_q - CNT_W'(1)) ? IDLE : RD;
                    rd_cnt_d = (rd_cnt_q == rd_len_q - CNT_W'(1)) ? rd_cnt_q : rd_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = state_q;
        endcase
        // Frame close only swaps banks when the reader is idle; otherwise the frame is discarded.
        if (close) begin
            wr_cnt_d  = '0;
            eop_cnt_d = '0;
            ovf_d     = 1'b0;
            if (wr_len != '0) begin
                if (state_q != IDLE) begin
                    drop_d = 1'b1;
                end else begin
                    wr_bank_d = ~wr_bank_q;
                    rd_len_d  = wr_len;
                    rd_cnt_d  = '0;
                    state_d   = RD;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            wr_bank_q <= 1'b0;
            wr_cnt_q  <= '0;
            eop_cnt_q <= '0;
            rd_cnt_q  <= '0;
            rd_len_q  <= '0;
            tx_data_q <= '0;
            drop_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_bank_q <= wr_bank_d;
            wr_cnt_q  <= wr_cnt_d;
            eop_cnt_q <= eop_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            rd_len_q  <= rd_len_d;
            tx_data_q <= tx_data_d;
            drop_q    <= drop_d;
            ovf_q     <= ovf_d;
        end
    end
endmodule

// File: tb/tb_pingpong_frame_sched.sv
// tb_pingpong_frame_sched: scoreboard bench with SPRAM and UART transmitter models.
module tb_pingpong_frame_sched;
    localparam int ADDR_W = 14;
    localparam int CNT_W = 9;
    localparam int FRAME_EOP = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx_ready = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic rx_eop = 1'b0;
    logic tx_busy = 1'b0;
    logic [ADDR_W-1:0] addr_a, addr_b;
    logic wren_a, wren_b;
    logic [15:0] din, dout_a, dout_b;
    logic tx_start, wr_bank, rd_active, frame_drop, wr_ovf;
    logic [7:0] tx_data;

    logic [15:0] mem_a [0:511];
    logic [15:0] mem_b [0:511];
    logic [ADDR_W-1:0] last_wr = '0;
    logic bad_wr = 1'b0;
    logic [7:0] q[$];
    logic [7:0] last_tx = 8'h00;
    int compared = 0;
    int mismatched = 0;
    int n_start = 0;
    int n_drop = 0;
    int busy_len = 2;
    int busy_cnt = 0;

    pingpong_frame_sched #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .FRAME_EOP(FRAME_EOP)) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_ready_i(rx_ready), .rx_data_i(rx_data), .rx_eop_i(rx_eop),
        .ram_addr_a_o(addr_a), .ram_wren_a_o(wren_a),
        .ram_addr_b_o(addr_b), .ram_wren_b_o(wren_b),
        .ram_din_o(din), .ram_dout_a_i(dout_a), .ram_dout_b_i(dout_b),
        .tx_start_o(tx_start), .tx_data_o(tx_data), .tx_busy_i(tx_busy),
        .wr_bank_o(wr_bank), .rd_active_o(rd_active),
        .frame_drop_o(frame_drop), .wr_ovf_o(wr_ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wren_a) mem_a[addr_a[8:0]] <= din;
        if (wren_b) mem_b[addr_b[8:0]] <= din;
        dout_a <= mem_a[addr_a[8:0]];
        dout_b <= mem_b[addr_b[8:0]];
        if (wren_a || wren_b) last_wr <= wren_a ? addr_a : addr_b;
        if ((wren_a && wren_b) || (wren_a && wr_bank) || (wren_b && !wr_bank)) bad_wr <= 1'b1;
    end

    // Transmitter model: accepts a start when idle and pops the scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            tx_busy = 1'b0;
            busy_cnt = 0;
        end else if (tx_busy) begin
            if (busy_cnt <= 1) tx_busy = 1'b0;
            busy_cnt--;
        end else if (tx_start) begin
            n_start++;
            compared++;
            if (q.size() == 0) begin
                mismatched++;
                $display("FAIL tx_unexpected: got byte %02h, scoreboard empty", tx_data);
            end else begin
                logic [7:0] exp;
                exp = q.pop_front();
                if (tx_data !== exp) begin
                    mismatched++;
                    $display("FAIL tx_data: got %02h, expected %02h", tx_data, exp);
                end
            end
            last_tx = tx_data;
            tx_busy = 1'b1;
            busy_cnt = busy_len;
        end
        if (frame_drop) n_drop++;
    end

    task automatic cyc(input bit rdy, input logic [7:0] d, input bit eop);
        rx_ready = rdy;
        rx_data = d;
        rx_eop = eop;
        @(negedge clk);
        rx_ready = 1'b0;
        rx_eop = 1'b0;
    endtask

    task automatic byte_in(input logic [7:0] d, input bit exp);
        if (exp) q.push_back(d);
        cyc(1'b1, d, 1'b0);
    endtask

    task automatic eops(input int n);
        repeat (n) cyc(1'b0, 8'h00, 1'b1);
    endtask

    task automatic wait_idle(input int bound);
        int k = 0;
        while (rd_active && k < bound) begin
            @(negedge clk);
            k++;
        end
        compared++;
        if (rd_active) begin
            mismatched++;
            $display("FAIL wait_idle: rd_active still %0b after %0d cycles, expected 0", rd_active, bound);
        end
    endtask

    task automatic check_empty(input string name);
        compared++;
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL %s: %0d bytes never transmitted, expected 0", name, q.size());
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        compared++;
        if ({wr_bank, tx_start, rd_active, frame_drop, wr_ovf, tx_data} !== 13'h0) begin
            mismatched++;
            $display("FAIL reset: got bank=%b start=%b act=%b drop=%b ovf=%b data=%02h, expected all 0",
                     wr_bank, tx_start, rd_active, frame_drop, wr_ovf, tx_data);
        end
        compared++;
        if (addr_a !== '0 || wren_a !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_addr: got addr_a=%0d wren_a=%b, expected 0/0", addr_a, wren_a);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int s0 = n_start;
        for (int i = 0; i < 5; i++) byte_in(8'h11 + 8'(i), 1'b1);
        eops(FRAME_EOP);
        compared++;
        if (wr_bank !== 1'b1) begin
            mismatched++;
            $display("FAIL basic_bank: got %b, expected 1", wr_bank);
        end
        wait_idle(200);
        repeat (2) @(negedge clk);
        compared++;
        if (n_start - s0 != 5) begin
            mismatched++;
            $display("FAIL basic_starts: got %0d, expected 5", n_start - s0);
        end
        check_empty("basic_empty");
    endtask

    task automatic test_drop;
        int s0 = n_start;
        int d0 = n_drop;
        int k = 0;
        logic wb;
        busy_len = 1000;
        byte_in(8'h31, 1'b1);
        byte_in(8'h32, 1'b1);
        eops(FRAME_EOP);
        wb = wr_bank;
        while (!tx_busy && k < 50) begin
            @(negedge clk);
            k++;
        end
        compared++;
        if (!tx_busy) begin
            mismatched++;
            $display("FAIL drop_busy: tx_busy got %b, expected 1", tx_busy);
        end
        for (int i = 0; i < 3; i++) byte_in(8'hC0 + 8'(i), 1'b0);
        eops(FRAME_EOP);
        repeat (2) @(negedge clk);
        compared++;
        if (n_drop - d0 != 1) begin
            mismatched++;
            $display("FAIL drop_pulse: got %0d pulses, expected 1", n_drop - d0);
        end
        compared++;
        if (wr_bank !== wb) begin
            mismatched++;
            $display("FAIL drop_bank: got %b, expected %b", wr_bank, wb);
        end
        wait_idle(5000);
        repeat (2) @(negedge clk);
        compared++;
        if (n_start - s0 != 2) begin
            mismatched++;
            $display("FAIL drop_starts: got %0d, expected 2", n_start - s0);
        end
        check_empty("drop_empty");
        busy_len = 2;
    endtask

    task automatic test_same_cycle;
        logic wb = wr_bank;
        byte_in(8'h21, 1'b1);
        byte_in(8'h22, 1'b1);
        eops(FRAME_EOP - 1);
        q.push_back(8'hAB);
        cyc(1'b1, 8'hAB, 1'b1);
        compared++;
        if (last_wr !== 14'd2) begin
            mismatched++;
            $display("FAIL same_addr: last write addr %0d, expected 2", last_wr);
        end
        compared++;
        if (wr_bank !== ~wb) begin
            mismatched++;
            $display("FAIL same_bank: got %b, expected %b", wr_bank, ~wb);
        end
        wait_idle(200);
        compared++;
        if (last_tx !== 8'hAB) begin
            mismatched++;
            $display("FAIL same_last: got %02h, expected ab", last_tx);
        end
        check_empty("same_empty");
    endtask

    task automatic test_empty;
        logic wb = wr_bank;
        int s0 = n_start;
        int d0 = n_drop;
        eops(FRAME_EOP);
        repeat (3) @(negedge clk);
        compared++;
        if (wr_bank !== wb || rd_active !== 1'b0 || n_start != s0 || n_drop != d0) begin
            mismatched++;
            $display("FAIL empty: bank=%b act=%b starts=%0d drops=%0d, expected %b/0/0/0",
                     wr_bank, rd_active, n_start - s0, n_drop - d0, wb);
        end
        byte_in(8'h5A, 1'b1);
        eops(FRAME_EOP - 1);
        compared++;
        if (wr_bank !== wb) begin
            mismatched++;
            $display("FAIL empty_early: bank got %b, expected %b", wr_bank, wb);
        end
        eops(1);
        compared++;
        if (wr_bank !== ~wb) begin
            mismatched++;
            $display("FAIL empty_close: bank got %b, expected %b", wr_bank, ~wb);
        end
        wait_idle(200);
        check_empty("empty_q");
    endtask

    task automatic test_ovf;
        int s0 = n_start;
        busy_len = 1;
        for (int i = 0; i < (1 << CNT_W) + 2; i++) begin
            logic [7:0] b;
            b = i[7:0];
            byte_in(b, i < (1 << CNT_W) - 1);
        end
        compared++;
        if (wr_ovf !== 1'b1) begin
            mismatched++;
            $display("FAIL ovf_flag: got %b, expected 1", wr_ovf);
        end
        compared++;
        if (last_wr !== 14'd510) begin
            mismatched++;
            $display("FAIL ovf_addr: last write addr %0d, expected 510", last_wr);
        end
        eops(FRAME_EOP);
        compared++;
        if (wr_ovf !== 1'b0) begin
            mismatched++;
            $display("FAIL ovf_clear: got %b, expected 0", wr_ovf);
        end
        wait_idle(6000);
        repeat (2) @(negedge clk);
        compared++;
        if (n_start - s0 != 511) begin
            mismatched++;
            $display("FAIL ovf_starts: got %0d, expected 511", n_start - s0);
        end
        check_empty("ovf_empty");
        busy_len = 2;
    endtask

    task automatic test_reset_mid;
        int k = 0;
        byte_in(8'h41, 1'b1);
        byte_in(8'h42, 1'b1);
        byte_in(8'h43, 1'b1);
        eops(FRAME_EOP);
        while (!tx_start && k < 50) begin
            @(negedge clk);
            k++;
        end
        compared++;
        if (!tx_start) begin
            mismatched++;
            $display("FAIL mid_start: tx_start got %b, expected 1", tx_start);
        end
        #3 rst_n = 1'b0;
        #1;
        compared++;
        if (tx_start !== 1'b0 || rd_active !== 1'b0 || wr_bank !== 1'b0) begin
            mismatched++;
            $display("FAIL mid_reset: start=%b act=%b bank=%b, expected 0/0/0", tx_start, rd_active, wr_bank);
        end
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        byte_in(8'h77, 1'b1);
        compared++;
        if (last_wr !== '0 || mem_a[0] !== 16'h0077) begin
            mismatched++;
            $display("FAIL mid_restart: addr=%0d memA0=%04h, expected 0/0077", last_wr, mem_a[0]);
        end
        eops(FRAME_EOP);
        wait_idle(200);
        check_empty("mid_empty");
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_basic;
        test_drop;
        test_same_cycle;
        test_empty;
        test_ovf;
        test_reset_mid;
        compared++;
        if (bad_wr !== 1'b0) begin
            mismatched++;
            $display("FAIL bank_guard: read-bank write seen %b, expected 0", bad_wr);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
